// File: rtl/cram_cfg_pkg.sv
// rtl/cram_cfg_pkg.sv - shared types and constants for the cram16x4 configuration loader
package cram_cfg_pkg;

  localparam int CRAM_ROWS = 16;
  localparam int CRAM_COLS = 4;
  localparam int ROW_W     = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_CLEAR = 2'b01,
    OP_READ  = 2'b10,
    OP_ILL   = 2'b11
  } cram_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_READ  = 3'd5
  } cram_state_e;

  // The phase counter runs down to zero, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cram_row_decoder.sv
// rtl/cram_row_decoder.sv - 4-to-16 one-hot row decoder with enable
module cram_row_decoder
  import cram_cfg_pkg::*;
(
  input  logic                 en,
  input  logic [ROW_W-1:0]     row,
  output logic [CRAM_ROWS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[row] = 1'b1;
  end

endmodule

// File: rtl/cram_cfg_loader.sv
// rtl/cram_cfg_loader.sv - cram16x4 wordline/bitline programming sequencer
// Optional row readback is enabled by defining CRAM_READBACK_EN.
module cram_cfg_loader
  import cram_cfg_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ROW_W-1:0]     cmd_row,
  input  logic [CRAM_COLS-1:0] cmd_data,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic                 prog,
  output logic [CRAM_ROWS-1:0] wl,
  output logic [CRAM_ROWS-1:0] pgate,
  output logic [CRAM_ROWS-1:0] reset_b,
  output logic [CRAM_ROWS-1:0] vdd_cntl,
  output logic [CRAM_COLS-1:0] bl_out,
  output logic                 bl_oe,
  input  logic [CRAM_COLS-1:0] bl_in,
  output logic                 rd_valid,
  output logic [CRAM_COLS-1:0] rd_data
);

  cram_state_e          state, state_nxt;
  cram_op_e             op;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ROW_W-1:0]     row_q, row_nxt;
  logic [CRAM_COLS-1:0] data_q, data_nxt;
  logic                 accept;
  logic                 done_nxt, err_nxt;
  logic                 dec_en, drive;
  logic [CRAM_ROWS-1:0] dec_oh;
  logic [CRAM_ROWS-1:0] wl_nxt, pgate_nxt, vdd_nxt, reset_b_nxt;
  logic [CRAM_COLS-1:0] bl_out_nxt;
  logic                 bl_oe_nxt;

  assign op        = cram_op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign row_nxt   = accept ? cmd_row  : row_q;
  assign data_nxt  = accept ? cmd_data : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      row_q  <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      row_q  <= row_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_WRITE: begin
              state_nxt = ST_SETUP;
              cnt_nxt   = cnt_load(SETUP_CYC);
            end
            OP_CLEAR: begin
              state_nxt = ST_CLEAR;
              cnt_nxt   = cnt_load(CLR_CYC);
            end
`ifdef CRAM_READBACK_EN
            OP_READ: begin
              state_nxt = ST_READ;
              cnt_nxt   = cnt_load(PULSE_CYC);
            end
`endif
            default: begin
              done_nxt = 1'b1;
              err_nxt  = 1'b1;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = cnt_load(PULSE_CYC);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = cnt_load(HOLD_CYC);
        end
      end
      ST_HOLD, ST_CLEAR, ST_READ: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the array pins never glitch.
  assign dec_en = (state_nxt == ST_PULSE) || (state_nxt == ST_READ);

  cram_row_decoder u_row_dec (
    .en     (dec_en),
    .row    (row_nxt),
    .onehot (dec_oh)
  );

  always_comb begin
    drive       = (state_nxt == ST_SETUP) || (state_nxt == ST_PULSE) || (state_nxt == ST_HOLD);
    wl_nxt      = dec_oh;
    pgate_nxt   = dec_oh;
    vdd_nxt     = (state_nxt == ST_PULSE) ? dec_oh : '0;
    reset_b_nxt = (state_nxt == ST_CLEAR) ? '0 : '1;
    bl_oe_nxt   = drive;
    bl_out_nxt  = drive ? data_nxt : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wl       <= '0;
      pgate    <= '0;
      reset_b  <= '1;
      vdd_cntl <= '0;
      bl_out   <= '0;
      bl_oe    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wl       <= wl_nxt;
      pgate    <= pgate_nxt;
      reset_b  <= reset_b_nxt;
      vdd_cntl <= vdd_nxt;
      bl_out   <= bl_out_nxt;
      bl_oe    <= bl_oe_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      busy     <= (state_nxt != ST_IDLE);
    end
  end

  assign prog = busy;

`ifdef CRAM_READBACK_EN
  // The bitlines are sensed on the final cycle of the read pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= (state == ST_READ) && (cnt == '0);
      if ((state == ST_READ) && (cnt == '0)) rd_data <= bl_in;
    end
  end
`else
  logic unused_bl_in;
  assign unused_bl_in = ^bl_in;
  assign rd_valid     = 1'b0;
  assign rd_data      = '0;
`endif

endmodule

// File: tb/tb_cram_cfg_loader.sv
// tb/tb_cram_cfg_loader.sv - directed scoreboard bench for cram_cfg_loader
module tb_cram_cfg_loader;
  import cram_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_row = 4'h0;
  logic [3:0]  cmd_data = 4'h0;
  logic        done, err, busy, prog;
  logic [15:0] wl, pgate, reset_b, vdd_cntl;
  logic [3:0]  bl_out;
  logic        bl_oe;
  logic [3:0]  bl_in = 4'h0;
  logic        rd_valid;
  logic [3:0]  rd_data;

  always #5 clk = ~clk;

  cram_cfg_loader dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_data  (cmd_data),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .prog      (prog),
    .wl        (wl),
    .pgate     (pgate),
    .reset_b   (reset_b),
    .vdd_cntl  (vdd_cntl),
    .bl_out    (bl_out),
    .bl_oe     (bl_oe),
    .bl_in     (bl_in),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  typedef struct packed {
    logic [15:0] wl;
    logic [15:0] pgate;
    logic [15:0] reset_b;
    logic [15:0] vdd;
    logic [3:0]  bl_out;
    logic        bl_oe;
    logic        busy;
    logic        prog;
    logic        done;
    logic        err;
    logic        rd_valid;
  } bus_t;

  typedef struct packed {
    logic       err;
    logic       rdv;
    logic [3:0] rdata;
  } resp_t;

  resp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bus_t sample_bus();
    bus_t b;
    b.wl = wl; b.pgate = pgate; b.reset_b = reset_b; b.vdd = vdd_cntl;
    b.bl_out = bl_out; b.bl_oe = bl_oe; b.busy = busy; b.prog = prog;
    b.done = done; b.err = err; b.rd_valid = rd_valid;
    return b;
  endfunction

  function automatic bus_t idle_bus();
    bus_t b;
    b = '0;
    b.reset_b = 16'hFFFF;
    return b;
  endfunction

  // Cycle (counted from the accept edge) in which done is expected, default timing.
  function automatic int done_cyc(input logic [1:0] op);
    case (op)
      2'b00: return 8;
      2'b01: return 9;
`ifdef CRAM_READBACK_EN
      2'b10: return 5;
`endif
      default: return 1;
    endcase
  endfunction

  function automatic bus_t exp_bus(input logic [1:0] op, input logic [3:0] row,
                                   input logic [3:0] data, input int c);
    bus_t b;
    int dc;
    logic [15:0] sel;
    b   = idle_bus();
    dc  = done_cyc(op);
    sel = 16'h0001 << row;
    b.busy = (c < dc);
    b.prog = b.busy;
    b.done = (c == dc);
    b.err  = (c == dc) && (dc == 1);
    case (op)
      2'b00: begin
        if (c <= 7) begin b.bl_oe = 1'b1; b.bl_out = data; end
        if (c >= 3 && c <= 6) begin b.wl = sel; b.pgate = sel; b.vdd = sel; end
      end
      2'b01: if (c <= 8) b.reset_b = 16'h0000;
`ifdef CRAM_READBACK_EN
      2'b10: begin
        if (c <= 4) begin b.wl = sel; b.pgate = sel; end
        b.rd_valid = (c == 5);
      end
`endif
      default: ;
    endcase
    return b;
  endfunction

  // Present a command, follow it cycle by cycle, and leave time in its done cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] row, input logic [3:0] data,
                         input bit chain, input logic [1:0] nop, input logic [3:0] nrow,
                         input logic [3:0] ndata, input string tag);
    resp_t r;
    int dc;
    dc = done_cyc(op);
    cmd_op = op; cmd_row = row; cmd_data = data; cmd_valid = 1'b1;
    chk({tag, "_ready"}, 80'(cmd_ready), 80'd1);
    r.err = (dc == 1);
    r.rdv = 1'b0;
    r.rdata = 4'h0;
`ifdef CRAM_READBACK_EN
    if (op == 2'b10) begin r.rdv = 1'b1; r.rdata = bl_in; end
`endif
    sb.push_back(r);
    @(posedge clk); #1;
    if (chain) begin
      cmd_op = nop; cmd_row = nrow; cmd_data = ndata;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = 1; c <= dc; c++) begin
      chk($sformatf("%s_bus_c%0d", tag, c), 80'(sample_bus()), 80'(exp_bus(op, row, data, c)));
      if (done === 1'b1) begin
        resp_t e;
        chk({tag, "_sb_depth"}, 80'(sb.size()), 80'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_resp"}, 80'({err, rd_valid}), 80'({e.err, e.rdv}));
          if (e.rdv) chk({tag, "_rd_data"}, 80'(rd_data), 80'(e.rdata));
        end
      end
      if (c < dc) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", 80'(sample_bus()), 80'(idle_bus()));
    chk("reset_rd", 80'({rd_valid, rd_data}), 80'd0);
    chk("reset_ready", 80'(cmd_ready), 80'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 80'(cmd_ready), 80'd1);

    run_cmd(2'b00, 4'd5, 4'hA, 1'b0, 2'b00, 4'd0, 4'h0, "write5");
    run_cmd(2'b01, 4'd0, 4'h0, 1'b0, 2'b00, 4'd0, 4'h0, "clear");
    run_cmd(2'b00, 4'd0, 4'h1, 1'b1, 2'b00, 4'd15, 4'hF, "b2b_row0");
    run_cmd(2'b00, 4'd15, 4'hF, 1'b0, 2'b00, 4'd0, 4'h0, "b2b_row15");
    run_cmd(2'b11, 4'd2, 4'h3, 1'b0, 2'b00, 4'd0, 4'h0, "illegal");
    bl_in = 4'h6;
    run_cmd(2'b10, 4'd9, 4'h0, 1'b0, 2'b00, 4'd0, 4'h0, "read9");
`ifndef CRAM_READBACK_EN
    chk("read_tied_rd_data", 80'(rd_data), 80'd0);
`endif
    bl_in = 4'h0;

    // Abort a write in its second pulse cycle.
    cmd_op = 2'b00; cmd_row = 4'd3; cmd_data = 4'h5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_pre_wl", 80'(wl), 80'(16'h0008));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_bus", 80'(sample_bus()), 80'(idle_bus()));
    chk("abort_ready_in_reset", 80'(cmd_ready), 80'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", 80'(cmd_ready), 80'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_quiet_c%0d", i), 80'(sample_bus()), 80'(idle_bus()));
    end
    run_cmd(2'b00, 4'd12, 4'h3, 1'b0, 2'b00, 4'd0, 4'h0, "after_abort");
    chk("sb_empty", 80'(sb.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
